// File: rtl/kp_pkg.sv
// kp_pkg: shared key codes, FSM state encoding and keypad key map for keypad_encoder.
package kp_pkg;

    localparam logic [3:0] KEY_NONE   = 4'b1111;
    localparam logic [3:0] KEY_SET    = 4'b1110;
    localparam logic [3:0] KEY_CANCEL = 4'b1101;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_REL} state_t;

    // Returns {valid, code}; row_n is the active-low row pattern with a single low bit.
    function automatic logic [4:0] key_map(input logic [3:0] row_n, input logic [1:0] col);
        logic [1:0] r;
        r = !row_n[0] ? 2'd0 : !row_n[1] ? 2'd1 : !row_n[2] ? 2'd2 : 2'd3;
        if (col == 2'd3)
            return {1'b0, KEY_NONE};
        if (r == 2'd3)
            return {1'b1, col == 2'd0 ? KEY_CANCEL : col == 2'd1 ? 4'b0000 : KEY_SET};
        return {1'b1, 4'(r) * 4'd3 + 4'(col) + 4'd1};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
    parameter int          W       = 4,
    parameter logic [W-1:0] RST_VAL = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: scans and debounces a 4x4 keypad, emitting one single-cycle lock key code per press.
module keypad_encoder
    import kp_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [3:0] row_sense,
    output logic [3:0] col_drive,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    state_t        state_q, state_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] dbcnt_q, dbcnt_d, dbcnt_inc;
    logic [3:0]    pat_q, pat_d;
    logic [3:0]    col_drive_q, col_drive_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic [3:0]    rows;
    logic [4:0]    mapped;
    logic          last, all_high;

    sync_2ff #(.W(4), .RST_VAL(4'b1111)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_sense),
        .q   (rows)
    );

    assign last      = dwell_q == DW'(SCAN_DIV - 1);
    assign all_high  = &rows;
    assign dbcnt_inc = dbcnt_q == CW'(DEBOUNCE_CNT) ? dbcnt_q : dbcnt_q + 1'b1;
    assign mapped    = key_map(pat_q, col_idx_q);

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        dbcnt_d   = dbcnt_q;
        pat_d     = pat_q;
        // EMIT holds the timer at zero so WAIT_REL starts on a fresh dwell
        dwell_d   = (last || state_q == EMIT) ? '0 : dwell_q + 1'b1;
        case (state_q)
            SCAN: if (last) begin
                if (all_high) begin
                    col_idx_d = col_idx_q + 2'd1;
                end else if ($onehot(~rows)) begin
                    pat_d   = rows;
                    dbcnt_d = CW'(1);
                    state_d = DEBOUNCE;
                end else begin
                    dbcnt_d = '0;
                    state_d = WAIT_REL;
                end
            end
            DEBOUNCE: if (last) begin
                dbcnt_d = rows == pat_q ? dbcnt_inc : '0;
                state_d = rows != pat_q ? SCAN : dbcnt_inc == CW'(DEBOUNCE_CNT) ? EMIT : DEBOUNCE;
            end
            EMIT: begin
                dbcnt_d = '0;
                state_d = WAIT_REL;
            end
            default: if (last) begin
                dbcnt_d = all_high ? dbcnt_inc : '0;
                if (all_high && dbcnt_inc == CW'(DEBOUNCE_CNT)) begin
                    dbcnt_d   = '0;
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = SCAN;
                end
            end
        endcase
        if (!ena) begin
            state_d   = SCAN;
            col_idx_d = '0;
            dwell_d   = '0;
            dbcnt_d   = '0;
        end
        key_valid_d = state_d == EMIT && mapped[4];
        key_code_d  = key_valid_d ? mapped[3:0] : KEY_NONE;
        key_held_d  = state_d == EMIT || (state_d == WAIT_REL && key_held_q);
        col_drive_d = ena ? ~(4'b0001 << col_idx_d) : 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            col_idx_q   <= '0;
            dwell_q     <= '0;
            dbcnt_q     <= '0;
            pat_q       <= 4'b1111;
            col_drive_q <= 4'b1111;
            key_code_q  <= KEY_NONE;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            dwell_q     <= dwell_d;
            dbcnt_q     <= dbcnt_d;
            pat_q       <= pat_d;
            col_drive_q <= col_drive_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_drive = col_drive_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: keypad matrix model driving keypad_encoder, with a queue of expected key codes.
module tb_keypad_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic [3:0]  row_sense;
    logic [3:0]  col_drive;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = '0;
    logic [3:0]  exp_q[$];
    logic        prev_valid = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .row_sense (row_sense),
        .col_drive (col_drive),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // keys[r*4+c] closed pulls row r low while column c is driven low
    always_comb begin
        for (int r = 0; r < 4; r++)
            row_sense[r] = ~|(keys[r*4 +: 4] & ~col_drive);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid) begin
            if (exp_q.size() == 0)
                chk("extra_emit", {28'd0, key_code}, 32'hF);
            else
                chk("code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
            if (prev_valid)
                chk("double_cycle", 32'd1, 32'd0);
        end else if (key_code != 4'b1111) begin
            chk("idle_code", {28'd0, key_code}, 32'hF);
        end
        prev_valid <= key_valid;
    end

    task automatic wait_col(input logic [3:0] v, input string tag);
        int n = 0;
        while (col_drive !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200)
            chk(tag, {28'd0, col_drive}, {28'd0, v});
    endtask

    task automatic press(input int r, input int c, input int hold, input logic [4:0] exp);
        keys[r*4+c] = 1'b1;
        if (exp[4])
            exp_q.push_back(exp[3:0]);
        repeat (hold) @(negedge clk);
        keys[r*4+c] = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        logic [3:0] e;
        logic       seen_a, seen_b;
        repeat (3) @(negedge clk);
        chk("rst_col", {28'd0, col_drive}, 32'hF);
        chk("rst_code", {28'd0, key_code}, 32'hF);
        chk("rst_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_held", {31'd0, key_held}, 32'd0);
        rst = 1'b0;
        // 1: idle scan, one column per 4 clocks
        wait_col(4'b1101, "scan_start");
        for (int i = 0; i < 16; i++) begin
            e = ~(4'b0001 << ((i / 4 + 1) % 4));
            chk("scan", {28'd0, col_drive}, {28'd0, e});
            @(negedge clk);
        end
        // 2: long hold of '5', one pulse, held until debounced release
        keys[5] = 1'b1;
        exp_q.push_back(4'b0101);
        repeat (200) @(negedge clk);
        chk("held_5", {31'd0, key_held}, 32'd1);
        keys[5] = 1'b0;
        repeat (8) @(negedge clk);
        chk("held_during_rel", {31'd0, key_held}, 32'd1);
        repeat (30) @(negedge clk);
        chk("held_released", {31'd0, key_held}, 32'd0);
        // 3: cancel, set, zero
        press(3, 0, 60, {1'b1, 4'b1101});
        press(3, 2, 60, {1'b1, 4'b1110});
        press(3, 1, 60, {1'b1, 4'b0000});
        // 4: '8' bounces after two good samples, then settles
        wait_col(4'b1101, "bounce_col");
        keys[9] = 1'b1;
        repeat (8) @(negedge clk);
        keys[9] = 1'b0;
        repeat (2) @(negedge clk);
        chk("bounce_no_emit", exp_q.size(), 0);
        press(2, 1, 80, {1'b1, 4'b1000});
        // 5: ghost '1'+'4', then unmapped 'A'
        keys[0] = 1'b1;
        keys[4] = 1'b1;
        repeat (60) @(negedge clk);
        chk("ghost_held", {31'd0, key_held}, 32'd0);
        keys[0] = 1'b0;
        keys[4] = 1'b0;
        repeat (40) @(negedge clk);
        press(0, 3, 60, 5'd0);
        seen_a = 1'b0;
        seen_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen_a |= col_drive == 4'b0111;
            seen_b |= col_drive == 4'b1110;
            @(negedge clk);
        end
        chk("resume_c3", {31'd0, seen_a}, 32'd1);
        chk("resume_c0", {31'd0, seen_b}, 32'd1);
        // 6: reset during debounce of '9', then report once after reset
        wait_col(4'b1011, "nine_col");
        keys[10] = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_col", {28'd0, col_drive}, 32'hF);
        chk("midrst_code", {28'd0, key_code}, 32'hF);
        chk("midrst_held", {31'd0, key_held}, 32'd0);
        repeat (3) @(negedge clk);
        exp_q.push_back(4'b1001);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("nine_held", {31'd0, key_held}, 32'd1);
        keys[10] = 1'b0;
        repeat (40) @(negedge clk);
        // ena drop during debounce of '9'
        wait_col(4'b1011, "nine_col2");
        keys[10] = 1'b1;
        repeat (6) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        chk("ena_col", {28'd0, col_drive}, 32'hF);
        chk("ena_held", {31'd0, key_held}, 32'd0);
        repeat (3) @(negedge clk);
        exp_q.push_back(4'b1001);
        ena = 1'b1;
        repeat (100) @(negedge clk);
        keys[10] = 1'b0;
        repeat (40) @(negedge clk);
        chk("leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
